// File: rtl/chacha_qr_core_if.sv
// Load/readback bundle for the iterative ChaCha quarter-round core.
// The master drives start/iters/words, the slave (core) returns status and results.
interface chacha_qr_core_if #(
   parameter int ITER_W = 4
);
   logic              start;
   logic [ITER_W-1:0] iters;
   logic [31:0]       a_in;
   logic [31:0]       b_in;
   logic [31:0]       c_in;
   logic [31:0]       d_in;
   logic              busy;
   logic              done;
   logic [31:0]       a_out;
   logic [31:0]       b_out;
   logic [31:0]       c_out;
   logic [31:0]       d_out;

   modport master (
      output start, iters, a_in, b_in, c_in, d_in,
      input  busy, done, a_out, b_out, c_out, d_out
   );

   modport slave (
      input  start, iters, a_in, b_in, c_in, d_in,
      output busy, done, a_out, b_out, c_out, d_out
   );
endinterface

// File: rtl/chacha_qr_core.sv
// Iterative ChaCha quarter-round engine: one ARX row per clock, 4 rows per round,
// `iters` rounds per start, then a one-cycle done pulse with registered results.
module chacha_qr_core #(
   parameter int ITER_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   chacha_qr_core_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            r_state;
   logic [31:0]       r_a;
   logic [31:0]       r_b;
   logic [31:0]       r_c;
   logic [31:0]       r_d;
   logic [1:0]        r_step;
   logic [ITER_W-1:0] r_remain;

   state_t            w_state_nxt;
   logic [31:0]       w_a_nxt;
   logic [31:0]       w_b_nxt;
   logic [31:0]       w_c_nxt;
   logic [31:0]       w_d_nxt;
   logic [1:0]        w_step_nxt;
   logic [ITER_W-1:0] w_remain_nxt;

   logic [31:0]       w_sum_ab;
   logic [31:0]       w_sum_cd;
   logic [31:0]       w_xor_d;
   logic [31:0]       w_xor_b;

   // Each row feeds the freshly added word straight into its xor/rotate.
   assign w_sum_ab = r_a + r_b;
   assign w_sum_cd = r_c + r_d;
   assign w_xor_d  = r_d ^ w_sum_ab;
   assign w_xor_b  = r_b ^ w_sum_cd;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no latch is inferred.
      w_state_nxt  = r_state;
      w_a_nxt      = r_a;
      w_b_nxt      = r_b;
      w_c_nxt      = r_c;
      w_d_nxt      = r_d;
      w_step_nxt   = r_step;
      w_remain_nxt = r_remain;

      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_a_nxt      = bus.a_in;
               w_b_nxt      = bus.b_in;
               w_c_nxt      = bus.c_in;
               w_d_nxt      = bus.d_in;
               w_remain_nxt = bus.iters;
               w_step_nxt   = 2'd0;
               w_state_nxt  = (bus.iters != '0) ? ST_RUN : ST_DONE;
            end
         end

         ST_RUN: begin
            w_step_nxt = r_step + 2'd1;
            case (r_step)
               2'd0: begin
                  w_a_nxt = w_sum_ab;
                  w_d_nxt = {w_xor_d[15:0], w_xor_d[31:16]};
               end
               2'd1: begin
                  w_c_nxt = w_sum_cd;
                  w_b_nxt = {w_xor_b[19:0], w_xor_b[31:20]};
               end
               2'd2: begin
                  w_a_nxt = w_sum_ab;
                  w_d_nxt = {w_xor_d[23:0], w_xor_d[31:24]};
               end
               default: begin
                  w_c_nxt      = w_sum_cd;
                  w_b_nxt      = {w_xor_b[24:0], w_xor_b[31:25]};
                  w_remain_nxt = r_remain - ITER_W'(1);
                  if (r_remain == ITER_W'(1)) begin
                     w_state_nxt = ST_DONE;
                  end
               end
            endcase
         end

         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_c      <= '0;
         r_d      <= '0;
         r_step   <= '0;
         r_remain <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_a      <= w_a_nxt;
         r_b      <= w_b_nxt;
         r_c      <= w_c_nxt;
         r_d      <= w_d_nxt;
         r_step   <= w_step_nxt;
         r_remain <= w_remain_nxt;
      end
   end

   // Status decodes only the registered state; no input reaches an output combinationally.
   assign bus.busy  = (r_state != ST_IDLE);
   assign bus.done  = (r_state == ST_DONE);
   assign bus.a_out = r_a;
   assign bus.b_out = r_b;
   assign bus.c_out = r_c;
   assign bus.d_out = r_d;

endmodule

// File: tb/tb_chacha_qr_core.sv
// Directed bench for chacha_qr_core: table of hand-computed vectors plus
// sequences for multi-round, start-while-busy and mid-run reset.
module tb_chacha_qr_core;

   localparam int ITER_W = 4;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic [31:0] d;
   } quad_t;

   typedef struct {
      string       name;
      quad_t       in;
      logic [3:0]  iters;
      quad_t       exp;
      int          edges;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_bad = 0;

   chacha_qr_core_if #(.ITER_W(ITER_W)) bus ();

   chacha_qr_core #(.ITER_W(ITER_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference quarter round, written the RFC way (whole round at a time).
   function automatic quad_t qr_model(input quad_t s, input int n);
      quad_t r;
      r = s;
      for (int i = 0; i < n; i++) begin
         r.a = r.a + r.b; r.d = r.d ^ r.a; r.d = {r.d[15:0], r.d[31:16]};
         r.c = r.c + r.d; r.b = r.b ^ r.c; r.b = {r.b[19:0], r.b[31:20]};
         r.a = r.a + r.b; r.d = r.d ^ r.a; r.d = {r.d[23:0], r.d[31:24]};
         r.c = r.c + r.d; r.b = r.b ^ r.c; r.b = {r.b[24:0], r.b[31:25]};
      end
      return r;
   endfunction

   // Pulses start and counts edges until done; with poke, re-asserts start with junk while busy.
   task automatic run_qr(input quad_t s, input logic [3:0] it, input bit poke,
                         output int edges, output int busy_cnt, output bit got_done);
      @(negedge clk);
      bus.a_in  = s.a;
      bus.b_in  = s.b;
      bus.c_in  = s.c;
      bus.d_in  = s.d;
      bus.iters = it;
      bus.start = 1'b1;
      edges     = 0;
      busy_cnt  = 0;
      got_done  = 1'b0;
      for (int k = 0; k < 80 && !got_done; k++) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         bus.start = 1'b0;
         if (bus.busy) busy_cnt++;
         if (bus.done) got_done = 1'b1;
         if (poke && bus.busy) begin
            bus.start = 1'b1;
            bus.a_in  = ~s.a;
            bus.b_in  = s.c;
            bus.c_in  = s.b;
            bus.d_in  = 32'h5a5a_5a5a;
            bus.iters = 4'd7;
         end
      end
   endtask

   task automatic verify(input string tag, input quad_t exp, input int exp_edges,
                         input int edges, input int busy_cnt, input bit got_done);
      check({tag, " done_seen"}, 32'(got_done), 32'd1);
      check({tag, " latency"},   32'(edges),    32'(exp_edges));
      check({tag, " busy_cyc"},  32'(busy_cnt), 32'(exp_edges));
      check({tag, " a"}, bus.a_out, exp.a);
      check({tag, " b"}, bus.b_out, exp.b);
      check({tag, " c"}, bus.c_out, exp.c);
      check({tag, " d"}, bus.d_out, exp.d);
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      check({tag, " idle_busy"}, 32'(bus.busy), 32'd0);
      check({tag, " idle_done"}, 32'(bus.done), 32'd0);
      check({tag, " hold_a"}, bus.a_out, exp.a);
      check({tag, " hold_d"}, bus.d_out, exp.d);
   endtask

   quad_t rfc_in;

   initial begin
      vec_t  vecs[4];
      quad_t exp_q;
      int    edges;
      int    busy_cnt;
      bit    got_done;
      int    dcnt;

      rfc_in  = '{a: 32'h1111_1111, b: 32'h0102_0304, c: 32'h9b8d_6f43, d: 32'h0123_4567};
      vecs[0] = '{"rfc",   rfc_in, 4'd1,
                  '{a: 32'hea2a_92f4, b: 32'hcb1c_f8ce, c: 32'h4581_472e, d: 32'h5881_c4bb}, 5};
      vecs[1] = '{"carry", '{a: 32'hffff_ffff, b: 32'h0000_0001, c: 32'h0, d: 32'h0}, 4'd1,
                  '{a: 32'h0000_1000, b: 32'h0808_0000, c: 32'h0010_0000, d: 32'h0010_0000}, 5};
      vecs[2] = '{"zero_it", '{a: 32'hdead_beef, b: 32'h1234_5678, c: 32'hcafe_f00d, d: 32'h0bad_c0de}, 4'd0,
                  '{a: 32'hdead_beef, b: 32'h1234_5678, c: 32'hcafe_f00d, d: 32'h0bad_c0de}, 1};
      vecs[3] = '{"all_zero", '{a: 32'h0, b: 32'h0, c: 32'h0, d: 32'h0}, 4'd2,
                  '{a: 32'h0, b: 32'h0, c: 32'h0, d: 32'h0}, 9};

      bus.start = 1'b0;
      bus.iters = '0;
      bus.a_in  = '0;
      bus.b_in  = '0;
      bus.c_in  = '0;
      bus.d_in  = '0;

      // Reset state, and reset beating a simultaneous start.
      repeat (3) @(negedge clk);
      bus.a_in  = 32'h1234_5678;
      bus.iters = 4'd1;
      bus.start = 1'b1;
      @(negedge clk);
      check("rst busy",  32'(bus.busy), 32'd0);
      check("rst done",  32'(bus.done), 32'd0);
      check("rst a_out", bus.a_out, 32'h0);
      check("rst b_out", bus.b_out, 32'h0);
      check("rst c_out", bus.c_out, 32'h0);
      check("rst d_out", bus.d_out, 32'h0);
      bus.start = 1'b0;
      rst       = 1'b0;

      for (int i = 0; i < 4; i++) begin
         run_qr(vecs[i].in, vecs[i].iters, 1'b0, edges, busy_cnt, got_done);
         verify(vecs[i].name, vecs[i].exp, vecs[i].edges, edges, busy_cnt, got_done);
      end

      // Multiple rounds against the reference model, including the maximum count.
      run_qr(rfc_in, 4'd3, 1'b0, edges, busy_cnt, got_done);
      verify("multi3", qr_model(rfc_in, 3), 13, edges, busy_cnt, got_done);
      exp_q = qr_model('{a: 32'h6170_7865, b: 32'h3320_646e, c: 32'h7962_2d32, d: 32'h6b20_6574}, 15);
      run_qr('{a: 32'h6170_7865, b: 32'h3320_646e, c: 32'h7962_2d32, d: 32'h6b20_6574},
             4'd15, 1'b0, edges, busy_cnt, got_done);
      verify("max15", exp_q, 61, edges, busy_cnt, got_done);

      // Start held with other inputs through RUN and the DONE cycle must change nothing.
      run_qr(rfc_in, 4'd1, 1'b1, edges, busy_cnt, got_done);
      verify("busy_start", vecs[0].exp, 5, edges, busy_cnt, got_done);
      repeat (2) @(negedge clk);
      check("busy_start stays_idle", 32'(bus.busy), 32'd0);

      // Reset landing on step 2 of the first round aborts with no done pulse.
      @(negedge clk);
      bus.a_in  = rfc_in.a;
      bus.b_in  = rfc_in.b;
      bus.c_in  = rfc_in.c;
      bus.d_in  = rfc_in.d;
      bus.iters = 4'd3;
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      check("abort pre_busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("abort busy",  32'(bus.busy), 32'd0);
      check("abort done",  32'(bus.done), 32'd0);
      check("abort a_out", bus.a_out, 32'h0);
      check("abort b_out", bus.b_out, 32'h0);
      check("abort c_out", bus.c_out, 32'h0);
      check("abort d_out", bus.d_out, 32'h0);
      dcnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.done || bus.busy) dcnt++;
      end
      check("abort no_done", 32'(dcnt), 32'd0);

      run_qr(rfc_in, 4'd1, 1'b0, edges, busy_cnt, got_done);
      verify("post_abort", vecs[0].exp, 5, edges, busy_cnt, got_done);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
